// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART frame serializer (start, LSB-first data, optional parity under UART_TX_PARITY_EN, stop)
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;
  state_t                r_state, w_state;
  logic                  r_tx, w_tx, r_busy, w_busy;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0] r_data, w_data;
`ifdef UART_TX_PARITY_EN
  logic                  r_pen, w_pen, r_par, w_par;
`else
  logic                  w_unused;
  assign w_unused = PAR_EN ^ PAR_TYP;
`endif
  // outputs are computed for the next cycle and registered with the state
  always_comb begin
    w_state = IDLE;
    w_tx    = 1'b1;
    w_busy  = 1'b0;
    w_cnt   = r_cnt;
    w_data  = r_data;
`ifdef UART_TX_PARITY_EN
    w_pen   = r_pen;
    w_par   = r_par;
`endif
    case (r_state)
      IDLE, STOP: if (DATA_VALID) begin
        w_state = START;
        w_tx    = 1'b0;
        w_busy  = 1'b1;
        w_cnt   = '0;
        w_data  = P_DATA;
`ifdef UART_TX_PARITY_EN
        w_pen   = PAR_EN;
        w_par   = PAR_TYP ^ (^P_DATA);
`endif
      end
      START: begin
        w_state = DATA;
        w_tx    = r_data[0];
        w_data  = r_data >> 1;
        w_busy  = 1'b1;
        w_cnt   = '0;
      end
      DATA: begin
        w_busy = 1'b1;
        if (r_cnt == LAST) begin
`ifdef UART_TX_PARITY_EN
          w_state = r_pen ? PARITY : STOP;
          w_tx    = r_pen ? r_par : 1'b1;
`else
          w_state = STOP;
`endif
        end else begin
          w_state = DATA;
          w_tx    = r_data[0];
          w_data  = r_data >> 1;
          w_cnt   = r_cnt + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_state = STOP;
        w_busy  = 1'b1;
      end
`endif
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_data  <= '0;
`ifdef UART_TX_PARITY_EN
      r_pen   <= 1'b0;
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      r_cnt   <= w_cnt;
      r_data  <= w_data;
`ifdef UART_TX_PARITY_EN
      r_pen   <= w_pen;
      r_par   <= w_par;
`endif
    end
  end
  assign TX_OUT = r_tx;
  assign busy   = r_busy;
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed self-checking bench for uart_tx_framer
module tb_uart_tx_framer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT, busy;
  int         checks = 0;
  int         errors = 0;
  uart_tx_framer #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({TX_OUT, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", TX_OUT, busy);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({TX_OUT, busy} !== 2'b10) begin
        errors++;
        $display("FAIL idle cycle %0d: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", i, TX_OUT, busy);
      end
    end
  endtask
  task automatic test_no_parity();
    logic [9:0] exp = {1'b1, 8'hA5, 1'b0};
    P_DATA = 8'hA5; PAR_EN = 1'b0; DATA_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      DATA_VALID = 1'b0;
      checks++;
      if ({TX_OUT, busy} !== {exp[i], 1'b1}) begin
        errors++;
        $display("FAIL no_parity cycle %0d: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=1", i, TX_OUT, busy, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({TX_OUT, busy} !== 2'b10) begin
      errors++;
      $display("FAIL no_parity end: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", TX_OUT, busy);
    end
  endtask
  task automatic test_parity(input logic typ);
`ifdef UART_TX_PARITY_EN
    localparam int N = 11;
    logic [10:0] exp = {1'b1, typ, 8'hA5, 1'b0};
`else
    localparam int N = 10;
    logic [9:0] exp = {1'b1, 8'hA5, 1'b0};
`endif
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = typ; DATA_VALID = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      DATA_VALID = 1'b0;
      checks++;
      if ({TX_OUT, busy} !== {exp[i], 1'b1}) begin
        errors++;
        $display("FAIL parity typ=%b cycle %0d: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=1", typ, i, TX_OUT, busy, exp[i]);
      end
    end
    @(negedge clk);
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    checks++;
    if ({TX_OUT, busy} !== 2'b10) begin
      errors++;
      $display("FAIL parity typ=%b end: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", typ, TX_OUT, busy);
    end
  endtask
  task automatic test_back_to_back();
    logic [19:0] exp = {1'b1, 8'hF0, 1'b0, 1'b1, 8'h0F, 1'b0};
    P_DATA = 8'h0F; DATA_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({TX_OUT, busy} !== {exp[i], 1'b1}) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=1", i, TX_OUT, busy, exp[i]);
      end
      if (i == 8) P_DATA = 8'hF0;
      if (i == 10) DATA_VALID = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({TX_OUT, busy} !== 2'b10) begin
      errors++;
      $display("FAIL back_to_back end: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", TX_OUT, busy);
    end
  endtask
  task automatic test_ignore();
    logic [9:0] exp = {1'b1, 8'hFF, 1'b0};
    P_DATA = 8'hFF; DATA_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      DATA_VALID = (i == 4);
      if (i == 2) P_DATA = 8'h00;
      checks++;
      if ({TX_OUT, busy} !== {exp[i], 1'b1}) begin
        errors++;
        $display("FAIL ignore cycle %0d: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=1", i, TX_OUT, busy, exp[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({TX_OUT, busy} !== 2'b10) begin
        errors++;
        $display("FAIL ignore idle %0d: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", i, TX_OUT, busy);
      end
    end
  endtask
  task automatic test_mid_reset();
    logic [9:0] exp = {1'b1, 8'h3C, 1'b0};
    P_DATA = 8'hA5; DATA_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      DATA_VALID = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({TX_OUT, busy} !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset abort: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", TX_OUT, busy);
    end
    rst = 1'b1; P_DATA = 8'h3C; DATA_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      DATA_VALID = 1'b0;
      checks++;
      if ({TX_OUT, busy} !== {exp[i], 1'b1}) begin
        errors++;
        $display("FAIL mid_reset frame cycle %0d: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=1", i, TX_OUT, busy, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({TX_OUT, busy} !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset end: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0", TX_OUT, busy);
    end
  endtask
  initial begin
    test_reset();
    test_no_parity();
    test_parity(1'b0);
    test_parity(1'b1);
    test_back_to_back();
    test_ignore();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of payload bits per frame.
REQ-002 SHALL have port clk  input  1  TX bit clock, one serial bit per rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel byte to send.
REQ-005 SHALL have port DATA_VALID  input  1  request to send P_DATA, a one-cycle or level strobe.
REQ-006 SHALL have port PAR_EN  input  1  enables the parity bit (1 = enabled).
REQ-007 SHALL have port PAR_TYP  input  1  parity type (0 = even, 1 = odd).
REQ-008 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is being shifted out.

Function
REQ-010 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP, with every output registered.
REQ-011 IDLE SHALL drive TX_OUT=1 and busy=0, and SHALL move to START on the edge where DATA_VALID=1.
REQ-012 SHALL latch P_DATA, PAR_EN and PAR_TYP on the acceptance edge; input changes while busy=1 SHALL be ignored.
REQ-013 Latency: with DATA_VALID=1 sampled at edge n, the edge-n register update SHALL put TX_OUT=0 (start bit) and busy=1, so both are visible in cycle n+1.
REQ-014 START SHALL last 1 cycle, then move to DATA.
REQ-015 DATA SHALL last DATA_WIDTH cycles, sending the latched data LSB first; a bit counter sized ceil(log2(DATA_WIDTH)) SHALL count from 0 to DATA_WIDTH-1.
REQ-016 After the last data bit, the FSM SHALL go to PARITY if the latched PAR_EN=1, else to STOP.
REQ-017 PARITY SHALL last 1 cycle and drive the XOR-reduction of the latched data for even parity, or its inverse for odd parity.
REQ-018 STOP SHALL last 1 cycle and drive TX_OUT=1.
REQ-019 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity.
REQ-020 Back-to-back frames: if DATA_VALID=1 is sampled at the edge ending the STOP cycle, the FSM SHALL go directly to START with new data latched, busy SHALL stay 1, and no idle bit SHALL be inserted.
REQ-021 If DATA_VALID=0 at the end of STOP, the FSM SHALL return to IDLE and busy SHALL fall in the following cycle.
REQ-022 DATA_VALID asserted in START, DATA or PARITY SHALL be dropped, with no queuing.
REQ-023 Unreachable state encodings SHALL recover to IDLE on the next edge with TX_OUT=1.

Reset
REQ-024 While rst=0 at a rising edge: state=IDLE, TX_OUT=1, busy=0, and the bit counter and data latch SHALL be cleared.
REQ-025 Reset asserted mid-frame SHALL abort the frame, returning TX_OUT to 1 on the reset edge with no partial stop bit.
REQ-026 The first DATA_VALID SHALL be accepted at the first edge after rst returns to 1.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined SHALL compile in the parity logic and the PARITY state, giving the behaviour of REQ-016/017.
REQ-028 Without UART_TX_PARITY_EN: the PARITY state and logic SHALL be absent, PAR_EN and PAR_TYP SHALL remain as ports but be ignored, and every frame SHALL be DATA_WIDTH+2 cycles.

Verification
REQ-029 Scenario: reset, then idle for 5 cycles -> TX_OUT=1 and busy=0 throughout.
REQ-030 Scenario: P_DATA=0xA5, PAR_EN=0, one-cycle DATA_VALID -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, then idle 1; busy high for exactly 10 cycles.
REQ-031 Scenario: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0 (11 cycles); with PAR_TYP=1 -> parity bit 1.
REQ-032 Scenario: DATA_VALID held high with 0x0F, then 0xF0 presented on the STOP cycle -> second start bit immediately follows the first stop bit, busy never drops, and 20 cycles total.
REQ-033 Scenario: P_DATA changed to 0x00 during DATA of a 0xFF frame -> all eight data bits are 1; a DATA_VALID pulse in DATA is ignored.
REQ-034 Scenario: rst=0 asserted during the 4th data bit -> TX_OUT=1 and busy=0 on the next edge; the next DATA_VALID produces a clean full frame.
